cpu_hazard_scoreboard: RTL

CPU_HAZARD_SCOREBOARD -- requirements
Module: cpu_hazard_scoreboard

---
 rtl/cpu_hazard_scoreboard_pkg.sv | 15 +
 rtl/cpu_hazard_scoreboard_if.sv | 47 ++++
 rtl/cpu_hazard_scoreboard_mc_tracker.sv | 55 +++++
 rtl/cpu_hazard_scoreboard.sv | 91 +++++++++
 4 files changed

// File: rtl/cpu_hazard_scoreboard_pkg.sv
// Shared encodings for the hazard unit: forwarding selects and the
// multi-cycle tracker state.
package cpu_hazard_scoreboard_pkg;

  localparam logic [1:0] FORWARD_NONE      = 2'b00;
  localparam logic [1:0] FORWARD_WRITEBACK = 2'b01;
  localparam logic [1:0] FORWARD_MEMORY    = 2'b10;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'b00,
    MC_BUSY  = 2'b01,
    MC_GRANT = 2'b10
  } mc_state_t;

endpackage

// File: rtl/cpu_hazard_scoreboard_if.sv
// Pipeline <-> hazard unit signal bundle. The master side is the pipeline,
// the slave side is the hazard unit; mc_state is a debug view of the tracker.
// Handshake: mc_done is a level held by the multi-cycle unit until the cycle
// mc_wb_grant is high; mc_issue marks the single cycle an op is accepted.
interface cpu_hazard_scoreboard_if #(
    parameter int REG_AW = 5
);
    import cpu_hazard_scoreboard_pkg::*;

    logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
    logic              reg_write_d;
    logic              mc_op_d;
    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
    logic              load_e;
    logic              mc_start_e;
    logic              redirect_e;
    logic              reg_write_m, reg_write_w;
    logic [REG_AW-1:0] rd_m, rd_w;
    logic              mem_ready_m;
    logic              mc_done;
    logic [1:0]        forward_a_e, forward_b_e;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_w;
    logic              mc_issue;
    logic              mc_wb_grant;
    logic              mc_timeout;
    mc_state_t         mc_state;

    modport master (
        output rs1_d, rs2_d, rd_d, reg_write_d, mc_op_d,
               rs1_e, rs2_e, rd_e, load_e, mc_start_e, redirect_e,
               reg_write_m, reg_write_w, rd_m, rd_w, mem_ready_m, mc_done,
        input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, mc_issue, mc_wb_grant, mc_timeout,
               mc_state
    );

    modport slave (
        input  rs1_d, rs2_d, rd_d, reg_write_d, mc_op_d,
               rs1_e, rs2_e, rd_e, load_e, mc_start_e, redirect_e,
               reg_write_m, reg_write_w, rd_m, rd_w, mem_ready_m, mc_done,
        output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, mc_issue, mc_wb_grant, mc_timeout,
               mc_state
    );

endinterface

// File: rtl/cpu_hazard_scoreboard_mc_tracker.sv
// Tracks the single outstanding multi-cycle op: its destination register,
// how long it has been outstanding, and the one-cycle writeback grant.
module cpu_mc_tracker
    import cpu_hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int TO_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mc_issue,
    input  logic              mc_done,
    input  logic              mem_stall,
    input  logic [REG_AW-1:0] rd_e,
    output mc_state_t         state,
    output logic [REG_AW-1:0] pend_rd,
    output logic              timeout
);

    mc_state_t       state_n;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= MC_IDLE;
        else     state <= state_n;
    end

    // A finished result waits in BUSY while memory stalls, since the
    // writeback port cannot be taken while the pipeline is frozen.
    always_comb begin
        state_n = state;
        case (state)
            MC_IDLE:  if (mc_issue) state_n = MC_BUSY;
            MC_BUSY:  if (mc_done && !mem_stall) state_n = MC_GRANT;
            MC_GRANT: state_n = MC_IDLE;
            default:  state_n = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_rd <= '0;
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else if (state == MC_IDLE && mc_issue) begin
            pend_rd <= rd_e;
            to_cnt  <= '0;
        end else if (state == MC_BUSY) begin
            if (to_cnt != '1) to_cnt <= to_cnt + TO_W'(1);
            if (to_cnt == TO_W'(MC_TIMEOUT)) timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/cpu_hazard_scoreboard.sv
// Hazard unit: operand forwarding, load-use / scoreboard / structural stalls,
// redirect flushes, and arbitration of the multi-cycle writeback slot.
module cpu_hazard_scoreboard
    import cpu_hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int TO_W       = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    cpu_hazard_scoreboard_if.slave  hz
);

    mc_state_t         state;
    logic [REG_AW-1:0] pend_rd;
    logic              mem_stall;
    logic              grant;
    logic              hold_all;
    logic              sb_hazard;
    logic              struct_hazard;
    logic              load_use;
    logic              fd_hazard;
    logic              issue;

    cpu_mc_tracker #(
        .REG_AW     (REG_AW),
        .MC_TIMEOUT (MC_TIMEOUT),
        .TO_W       (TO_W)
    ) u_mc_tracker (
        .clk       (clk),
        .rst       (rst),
        .mc_issue  (issue),
        .mc_done   (hz.mc_done),
        .mem_stall (mem_stall),
        .rd_e      (hz.rd_e),
        .state     (state),
        .pend_rd   (pend_rd),
        .timeout   (hz.mc_timeout)
    );

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              wr_m,
        input logic [REG_AW-1:0] dst_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] dst_w
    );
        if (rs == '0)                    return FORWARD_NONE;
        else if (wr_m && dst_m == rs)    return FORWARD_MEMORY;
        else if (wr_w && dst_w == rs)    return FORWARD_WRITEBACK;
        else                             return FORWARD_NONE;
    endfunction

    always_comb begin
        hz.forward_a_e = fwd_sel(hz.rs1_e, hz.reg_write_m, hz.rd_m, hz.reg_write_w, hz.rd_w);
        hz.forward_b_e = fwd_sel(hz.rs2_e, hz.reg_write_m, hz.rd_m, hz.reg_write_w, hz.rd_w);
    end

    assign mem_stall = !hz.mem_ready_m;
    assign grant     = (state == MC_GRANT);
    assign hold_all  = mem_stall || grant;
    assign issue     = hz.mc_start_e && (state == MC_IDLE) && !mem_stall;

    assign sb_hazard = (state != MC_IDLE) && (pend_rd != '0) &&
                       ((hz.rs1_d == pend_rd) || (hz.rs2_d == pend_rd) ||
                        (hz.reg_write_d && (hz.rd_d == pend_rd)));

    assign struct_hazard = hz.mc_op_d && ((state != MC_IDLE) || issue);

    assign load_use = hz.load_e && (hz.rd_e != '0) &&
                      ((hz.rs1_d == hz.rd_e) || (hz.rs2_d == hz.rd_e));

    assign fd_hazard = sb_hazard || struct_hazard || load_use;

    // A full hold freezes E, so any redirect is replayed later and no bubble
    // is needed; otherwise a F/D stall must bubble E.
    always_comb begin
        hz.stall_f     = hold_all || fd_hazard;
        hz.stall_d     = hold_all || fd_hazard;
        hz.stall_e     = hold_all;
        hz.stall_m     = hold_all;
        hz.flush_w     = hold_all;
        hz.flush_d     = !hold_all && hz.redirect_e;
        hz.flush_e     = !hold_all && (fd_hazard || hz.redirect_e);
        hz.mc_issue    = issue;
        hz.mc_wb_grant = grant;
        hz.mc_state    = state;
    end

endmodule
